// File: rtl/alu.sv
// Registered 4-bit ALU: one-cycle latency, 8-bit result with zero flag.
// Asynchronous active-high reset clears all outputs immediately.
module alu (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [2:0] sel,
    input  logic       in_valid,
    output logic [7:0] result,
    output logic       out_valid,
    output logic       zero
);

    typedef enum logic [2:0] {
        OpAdd = 3'b000,
        OpSub = 3'b001,
        OpShl = 3'b010,
        OpAnd = 3'b011,
        OpOr  = 3'b100,
        OpNot = 3'b101,
        OpXor = 3'b110,
        OpShr = 3'b111
    } op_e;

    logic [7:0] a_ext;
    logic [7:0] b_ext;
    logic [7:0] result_d;
    logic [7:0] result_q;
    logic       out_valid_q;
    logic       zero_q;

    assign a_ext = {4'b0000, a};
    assign b_ext = {4'b0000, b};

    // Shifts use the full 4-bit b; amounts at or beyond the width yield 0.
    always_comb begin
        result_d = 8'h00;
        unique case (op_e'(sel))
            OpAdd:   result_d = a_ext + b_ext;
            OpSub:   result_d = a_ext - b_ext;
            OpShl:   result_d = a_ext << b;
            OpAnd:   result_d = a_ext & b_ext;
            OpOr:    result_d = a_ext | b_ext;
            OpNot:   result_d = {4'b0000, ~a};
            OpXor:   result_d = a_ext ^ b_ext;
            OpShr:   result_d = a_ext >> b;
            default: result_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q    <= 8'h00;
            out_valid_q <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                result_q <= result_d;
                zero_q   <= (result_d == 8'h00);
            end
        end
    end

    assign result    = result_q;
    assign out_valid = out_valid_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: captured samples queue expected results from an
// arithmetic reference model; a monitor pops and compares on out_valid.
module tb_alu;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] sel;
    logic       in_valid;
    logic [7:0] result;
    logic       out_valid;
    logic       zero;

    int errors = 0;
    int checks = 0;
    int exp_dir = -1;

    typedef struct {
        int res;
        int dir;
    } exp_t;

    exp_t sbq[$];

    alu dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .in_valid  (in_valid),
        .result    (result),
        .out_valid (out_valid),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model(int x, int y, int s);
        case (s)
            0:       return x + y;
            1:       return (x - y + 256) % 256;
            2:       return (x * (1 << y)) % 256;
            3:       return x & y;
            4:       return x | y;
            5:       return 15 - x;
            6:       return x ^ y;
            default: return x / (1 << y);
        endcase
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Capture what the DUT should sample at this edge.
    always @(posedge clk) begin
        if (!rst && in_valid) begin
            exp_t e;
            e.res = model(int'(a), int'(b), int'(sel));
            e.dir = exp_dir;
            sbq.push_back(e);
        end
    end

    // Monitor: compare one step after each rising edge.
    int last_res  = 0;
    int last_zero = 0;
    always @(posedge clk) begin
        #1;
        if (rst) begin
            check("reset_result", int'(result), 0);
            check("reset_valid", int'(out_valid), 0);
            check("reset_zero", int'(zero), 0);
            last_res  = 0;
            last_zero = 0;
        end else if (out_valid) begin
            if (sbq.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("result", int'(result), e.res);
                check("zero", int'(zero), (e.res == 0) ? 1 : 0);
                if (e.dir >= 0) check("directed_result", int'(result), e.dir);
                last_res  = int'(result);
                last_zero = int'(zero);
            end
        end else begin
            check("missing_out_valid", int'(sbq.size()), 0);
            check("hold_result", int'(result), last_res);
            check("hold_zero", int'(zero), last_zero);
        end
    end

    task automatic send(input int ta, input int tb, input int ts, input int e);
        @(negedge clk);
        a        = 4'(ta);
        b        = 4'(tb);
        sel      = 3'(ts);
        in_valid = 1'b1;
        exp_dir  = e;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            a        = 4'($urandom);
            b        = 4'($urandom);
            sel      = 3'($urandom);
            in_valid = 1'b0;
            exp_dir  = -1;
        end
    endtask

    initial begin
        int seq_exp[8];
        int wait_cycles;
        seq_exp = '{5, 1, 12, 2, 3, 12, 1, 0};
        rst      = 1'b1;
        a        = 4'd0;
        b        = 4'd0;
        sel      = 3'd0;
        in_valid = 1'b0;
        #2;
        check("init_result", int'(result), 0);
        check("init_valid", int'(out_valid), 0);
        check("init_zero", int'(zero), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Operation sweep with a=3, b=2, back-to-back.
        for (int s = 0; s < 8; s++) send(3, 2, s, seq_exp[s]);

        // Boundary values.
        send(15, 15, 0, 30);
        send(2, 3, 1, 255);
        send(15, 4, 2, 240);
        send(1, 8, 2, 0);
        send(8, 3, 7, 1);
        send(5, 4, 7, 0);

        // Zero flag set then cleared.
        send(9, 9, 6, 0);
        send(9, 0, 4, 9);

        // Hold while in_valid is low and inputs wander.
        send(3, 2, 0, 5);
        idle(3);

        // Asynchronous reset between edges.
        #2;
        check("pre_reset_result", int'(result), 5);
        rst = 1'b1;
        #1;
        check("async_result", int'(result), 0);
        check("async_valid", int'(out_valid), 0);
        check("async_zero", int'(zero), 0);
        @(negedge clk);
        a        = 4'd7;
        b        = 4'd7;
        sel      = 3'd0;
        in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        send(6, 7, 0, 13);
        send(12, 5, 6, 9);

        // Randomized traffic with gaps.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            else send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7), -1);
        end
        idle(1);

        wait_cycles = 0;
        while (sbq.size() != 0 && wait_cycles < 20) begin
            @(negedge clk);
            wait_cycles++;
        end
        check("drain_queue_empty", int'(sbq.size()), 0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameters: none; all operand and result widths below are fixed.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 a  input  4  operand A, unsigned.
REQ-005 b  input  4  operand B, unsigned; also the shift amount for shift operations.
REQ-006 sel  input  3  operation select.
REQ-007 in_valid  input  1  operands and sel are sampled on a rising edge only when this is high.
REQ-008 result  output  8  registered operation result.
REQ-009 out_valid  output  1  high for exactly one cycle when result is updated.
REQ-010 zero  output  1  registered flag, high when the updated result equals 8'h00.

Function
REQ-011 Each result value SHALL be the operation below on a and b, zero-extended to 8 bits unless stated otherwise:
- 000 ADD: a + b, carry kept in bit 4; range 0..30.
- 001 SUB: a - b, 8-bit two's complement; a < b wraps (2 - 3 = 8'hFF).
- 010 SHL: a << b, computed in 8 bits; bits shifted beyond bit 7 are lost; b >= 8 gives 0.
- 011 AND: a & b.
- 100 OR: a | b.
- 101 NOT: {4'b0000, ~a}; b is ignored.
- 110 XOR: a ^ b.
- 111 SHR: a >> b, logical; b >= 4 gives 0.
REQ-012 Latency SHALL be one cycle: operands sampled at edge N with in_valid high appear on result, with out_valid high, after edge N.
REQ-013 When in_valid is low at an edge, result and zero SHALL hold their previous values and out_valid SHALL be low.
REQ-014 Back-to-back valid inputs SHALL be accepted every cycle with no stall; out_valid stays high continuously.
REQ-015 zero SHALL be updated in the same cycle as result and reflect only the new result.
REQ-016 No combinational path SHALL exist from any input to any output.
REQ-017 No X SHALL propagate to outputs for any sel value; all 8 codes are defined.

Reset
REQ-018 Asserting rst SHALL immediately, without waiting for a clock edge, force result=8'h00, out_valid=0 and zero=0.
REQ-019 While rst is high, inputs SHALL be ignored and outputs held at reset values.
REQ-020 An operation sampled in the cycle rst asserts SHALL be discarded; the first valid output after release comes from the first in_valid sample at an edge where rst is low.

Verification
REQ-021 a=3, b=2, in_valid=1, sel stepped 000..111 on consecutive cycles -> result 5, 1, 12, 2, 3, 12, 1, 0, each one cycle after its sample, with out_valid high throughout.
REQ-022 Boundary values: ADD a=15,b=15 -> 30; SUB a=2,b=3 -> 255; SHL a=15,b=4 -> 240; SHL a=1,b=8 -> 0; SHR a=8,b=3 -> 1.
REQ-023 Zero flag: XOR a=9,b=9 -> result 0, zero=1; next sample OR a=9,b=0 -> result 9, zero=0.
REQ-024 Hold behaviour: ADD a=3,b=2 valid, then in_valid low for 3 cycles while a, b and sel change -> result stays 5, out_valid low in those cycles.
REQ-025 Asynchronous reset: assert rst between clock edges while result=5 -> outputs go to 0 immediately; release rst, then apply a valid sample -> the correct result appears one cycle later.
